// File: rtl/ray_result_collector.sv
// ray_result_collector
// Captures one result record per ray from the tracer, tags it with a sequential
// ray ID, and buffers it in a small first-word-fall-through FIFO for the host.
// It also keeps saturating hit/miss/timeout statistics and a sticky overflow flag.
module ray_result_collector #(
    parameter int COORD_WIDTH      = 16,
    parameter int STEP_COUNT_WIDTH = 16,
    parameter int DEPTH            = 8,
    parameter int ID_W             = 8,
    parameter int CNT_W            = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ray_done,
    input  logic                          ray_hit,
    input  logic                          ray_timeout,
    input  logic [COORD_WIDTH-1:0]        hit_voxel_x,
    input  logic [COORD_WIDTH-1:0]        hit_voxel_y,
    input  logic [COORD_WIDTH-1:0]        hit_voxel_z,
    input  logic [2:0]                    hit_face_id,
    input  logic [STEP_COUNT_WIDTH-1:0]   steps_taken,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ID_W-1:0]               res_id,
    output logic                          res_hit,
    output logic                          res_timeout,
    output logic [COORD_WIDTH-1:0]        res_x,
    output logic [COORD_WIDTH-1:0]        res_y,
    output logic [COORD_WIDTH-1:0]        res_z,
    output logic [2:0]                    res_face,
    output logic [STEP_COUNT_WIDTH-1:0]   res_steps,
    output logic [$clog2(DEPTH):0]        fifo_count,
    output logic                          fifo_full,
    output logic                          overflow,
    input  logic                          clear_stats,
    output logic [CNT_W-1:0]              hit_count,
    output logic [CNT_W-1:0]              miss_count,
    output logic [CNT_W-1:0]              timeout_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef struct packed {
        logic [ID_W-1:0]             id;
        logic                        hit;
        logic                        timeout;
        logic [COORD_WIDTH-1:0]      x;
        logic [COORD_WIDTH-1:0]      y;
        logic [COORD_WIDTH-1:0]      z;
        logic [2:0]                  face;
        logic [STEP_COUNT_WIDTH-1:0] steps;
    } rec_t;

    rec_t             mem [DEPTH];
    rec_t             head;
    rec_t             wr_rec;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    count;
    logic [ID_W-1:0]  next_id;
    logic             done_d;

    logic cap;
    logic pop;
    logic push;
    logic drop;
    logic is_full;

    // Rising edge of ray_done gives exactly one capture per done assertion.
    assign cap     = ray_done & ~done_d;
    assign is_full = (count == CW'(DEPTH));
    assign pop     = res_valid & res_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push    = cap & (~is_full | pop);
    assign drop    = cap & is_full & ~pop;

    // A coincident clear forces the stored tag to 0 so the host sees a fresh sequence.
    assign wr_rec = '{
        id:      clear_stats ? '0 : next_id,
        hit:     ray_hit,
        timeout: ray_timeout,
        x:       hit_voxel_x,
        y:       hit_voxel_y,
        z:       hit_voxel_z,
        face:    hit_face_id,
        steps:   steps_taken
    };

    assign head       = mem[rd_ptr];
    assign res_valid  = (count != '0);
    assign fifo_count = count;
    assign fifo_full  = is_full;

    // Data fields read as zero whenever there is no valid head.
    assign res_id      = res_valid ? head.id      : '0;
    assign res_hit     = res_valid ? head.hit     : 1'b0;
    assign res_timeout = res_valid ? head.timeout : 1'b0;
    assign res_x       = res_valid ? head.x       : '0;
    assign res_y       = res_valid ? head.y       : '0;
    assign res_z       = res_valid ? head.z       : '0;
    assign res_face    = res_valid ? head.face    : '0;
    assign res_steps   = res_valid ? head.steps   : '0;

    // Record storage; contents are meaningless outside the occupied window.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    // Pointers, occupancy and done edge detector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            done_d <= 1'b0;
        end else begin
            done_d <= ray_done;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Ray ID tag: advances on every capture, dropped ones included, so gaps are visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_id <= '0;
        end else if (clear_stats) begin
            next_id <= cap ? ID_W'(1) : '0;
        end else if (cap) begin
            next_id <= next_id + ID_W'(1);
        end
    end

    // Sticky overflow flag, set when a capture finds no room.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (clear_stats) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // Saturating statistics; a hit takes precedence over a timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count     <= '0;
            miss_count    <= '0;
            timeout_count <= '0;
        end else if (clear_stats) begin
            hit_count     <= '0;
            miss_count    <= '0;
            timeout_count <= '0;
        end else if (cap) begin
            if (ray_hit) begin
                if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            end else if (ray_timeout) begin
                if (timeout_count != '1) timeout_count <= timeout_count + CNT_W'(1);
            end else begin
                if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ray_result_collector.sv
// Directed testbench for ray_result_collector with hand-computed expectations.
module tb_ray_result_collector;

    logic        clk;
    logic        reset;
    logic        ray_done;
    logic        ray_hit;
    logic        ray_timeout;
    logic [15:0] hit_voxel_x;
    logic [15:0] hit_voxel_y;
    logic [15:0] hit_voxel_z;
    logic [2:0]  hit_face_id;
    logic [15:0] steps_taken;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_id;
    logic        res_hit;
    logic        res_timeout;
    logic [15:0] res_x;
    logic [15:0] res_y;
    logic [15:0] res_z;
    logic [2:0]  res_face;
    logic [15:0] res_steps;
    logic [3:0]  fifo_count;
    logic        fifo_full;
    logic        overflow;
    logic        clear_stats;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic [15:0] timeout_count;

    int checks = 0;
    int errors = 0;

    ray_result_collector #(
        .COORD_WIDTH(16), .STEP_COUNT_WIDTH(16), .DEPTH(8), .ID_W(8), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .ray_done(ray_done), .ray_hit(ray_hit), .ray_timeout(ray_timeout),
        .hit_voxel_x(hit_voxel_x), .hit_voxel_y(hit_voxel_y), .hit_voxel_z(hit_voxel_z),
        .hit_face_id(hit_face_id), .steps_taken(steps_taken),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_hit(res_hit), .res_timeout(res_timeout),
        .res_x(res_x), .res_y(res_y), .res_z(res_z),
        .res_face(res_face), .res_steps(res_steps),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow(overflow),
        .clear_stats(clear_stats),
        .hit_count(hit_count), .miss_count(miss_count), .timeout_count(timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        ray_done    = 1'b0;
        ray_hit     = 1'b0;
        ray_timeout = 1'b0;
        res_ready   = 1'b0;
        clear_stats = 1'b0;
        hit_voxel_x = '0;
        hit_voxel_y = '0;
        hit_voxel_z = '0;
        hit_face_id = '0;
        steps_taken = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One capture: done high for one cycle, then low for one cycle.
    task automatic pulse(input logic hit, input logic tmo);
        ray_done    = 1'b1;
        ray_hit     = hit;
        ray_timeout = tmo;
        tick();
        ray_done    = 1'b0;
        ray_hit     = 1'b0;
        ray_timeout = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (res_valid !== 1'b0 || fifo_count !== 4'd0 || fifo_full !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: valid=%0b count=%0d full=%0b ovf=%0b, required 0/0/0/0",
                     res_valid, fifo_count, fifo_full, overflow);
        end
        checks++;
        if (hit_count !== 16'd0 || miss_count !== 16'd0 || timeout_count !== 16'd0 || res_x !== 16'd0 || res_id !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_stats: hit=%0d miss=%0d tmo=%0d x=%0d id=%0d, required all 0",
                     hit_count, miss_count, timeout_count, res_x, res_id);
        end
    endtask

    task automatic test_single_ray();
        apply_reset();
        ray_done    = 1'b1;
        ray_hit     = 1'b1;
        hit_voxel_x = 16'd3;
        hit_voxel_y = 16'd7;
        hit_voxel_z = 16'd12;
        hit_face_id = 3'd2;
        steps_taken = 16'd9;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_pre_edge_valid: got %0b, required 0", res_valid);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || fifo_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL single_latency: valid=%0b count=%0d, required 1/1", res_valid, fifo_count);
        end
        for (int i = 0; i < 4; i++) tick();
        ray_done = 1'b0;
        ray_hit  = 1'b0;
        tick();
        checks++;
        if (fifo_count !== 4'd1 || hit_count !== 16'd1 || res_id !== 8'd0) begin
            errors++;
            $display("[TB] FAIL single_once: count=%0d hit=%0d id=%0d, required 1/1/0",
                     fifo_count, hit_count, res_id);
        end
        checks++;
        if (res_x !== 16'd3 || res_y !== 16'd7 || res_z !== 16'd12 || res_face !== 3'd2 ||
            res_steps !== 16'd9 || res_hit !== 1'b1 || res_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_data: xyz=%0d,%0d,%0d face=%0d steps=%0d hit=%0b tmo=%0b, required 3,7,12 2 9 1 0",
                     res_x, res_y, res_z, res_face, res_steps, res_hit, res_timeout);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || fifo_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL single_pop: valid=%0b count=%0d, required 0/0", res_valid, fifo_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] flags [3];
        flags[0] = 2'b10;
        flags[1] = 2'b01;
        flags[2] = 2'b00;
        apply_reset();
        for (int i = 0; i < 3; i++) pulse(flags[i][1], flags[i][0]);
        checks++;
        if (fifo_count !== 4'd3) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d, required 3", fifo_count);
        end
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_id !== 8'(i) || {res_hit, res_timeout} !== flags[i]) begin
                errors++;
                $display("[TB] FAIL b2b_head%0d: valid=%0b id=%0d flags=%b, required 1 %0d %b",
                         i, res_valid, res_id, {res_hit, res_timeout}, i, flags[i]);
            end
            tick();
        end
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || hit_count !== 16'd1 || timeout_count !== 16'd1 || miss_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL b2b_stats: valid=%0b hit=%0d tmo=%0d miss=%0d, required 0 1/1/1",
                     res_valid, hit_count, timeout_count, miss_count);
        end
        // Empty FIFO with ready high must not change anything.
        res_ready = 1'b1;
        tick();
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || fifo_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL empty_ready: valid=%0b count=%0d, required 0/0", res_valid, fifo_count);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 10; i++) pulse(1'b0, 1'b0);
        checks++;
        if (fifo_count !== 4'd8 || fifo_full !== 1'b1 || overflow !== 1'b1 || miss_count !== 16'd10) begin
            errors++;
            $display("[TB] FAIL ovf_state: count=%0d full=%0b ovf=%0b miss=%0d, required 8/1/1/10",
                     fifo_count, fifo_full, overflow, miss_count);
        end
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (res_id !== 8'(i)) begin
                errors++;
                $display("[TB] FAIL ovf_drain%0d: id=%0d, required %0d", i, res_id, i);
            end
            tick();
        end
        res_ready = 1'b0;
        pulse(1'b1, 1'b0);
        checks++;
        if (res_id !== 8'd10 || fifo_count !== 4'd1 || overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_gap_id: id=%0d count=%0d ovf=%0b, required 10/1/1", res_id, fifo_count, overflow);
        end
    endtask

    task automatic test_full_pop_cap();
        apply_reset();
        for (int i = 0; i < 8; i++) pulse(1'b0, 1'b1);
        ray_done    = 1'b1;
        ray_timeout = 1'b1;
        res_ready   = 1'b1;
        tick();
        ray_done    = 1'b0;
        ray_timeout = 1'b0;
        res_ready   = 1'b0;
        checks++;
        if (fifo_count !== 4'd8 || fifo_full !== 1'b1 || overflow !== 1'b0 || res_id !== 8'd1 || timeout_count !== 16'd9) begin
            errors++;
            $display("[TB] FAIL full_pop_cap: count=%0d full=%0b ovf=%0b head=%0d tmo=%0d, required 8/1/0/1/9",
                     fifo_count, fifo_full, overflow, res_id, timeout_count);
        end
        res_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        res_ready = 1'b0;
        checks++;
        if (res_id !== 8'd8 || fifo_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL full_pop_cap_tail: id=%0d count=%0d, required 8/1", res_id, fifo_count);
        end
    endtask

    task automatic test_clear_stats();
        logic [7:0] exp_ids [5];
        exp_ids[0] = 8'd0;
        exp_ids[1] = 8'd1;
        exp_ids[2] = 8'd2;
        exp_ids[3] = 8'd3;
        exp_ids[4] = 8'd0;
        apply_reset();
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b0);
        checks++;
        if (hit_count !== 16'd2 || timeout_count !== 16'd1 || miss_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL clr_before: hit=%0d tmo=%0d miss=%0d, required 2/1/1",
                     hit_count, timeout_count, miss_count);
        end
        ray_done    = 1'b1;
        ray_hit     = 1'b1;
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        ray_done    = 1'b0;
        ray_hit     = 1'b0;
        checks++;
        if (hit_count !== 16'd0 || timeout_count !== 16'd0 || miss_count !== 16'd0 || fifo_count !== 4'd5) begin
            errors++;
            $display("[TB] FAIL clr_cap: hit=%0d tmo=%0d miss=%0d count=%0d, required 0/0/0/5",
                     hit_count, timeout_count, miss_count, fifo_count);
        end
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_id !== exp_ids[i]) begin
                errors++;
                $display("[TB] FAIL clr_drain%0d: id=%0d, required %0d", i, res_id, exp_ids[i]);
            end
            tick();
        end
        res_ready = 1'b0;
        pulse(1'b0, 1'b0);
        checks++;
        if (res_id !== 8'd1 || miss_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL clr_next_id: id=%0d miss=%0d, required 1/1", res_id, miss_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0);
        res_ready = 1'b1;
        tick();
        tick();
        res_ready = 1'b0;
        checks++;
        if (fifo_count !== 4'd5 || res_id !== 8'd2) begin
            errors++;
            $display("[TB] FAIL mid_drain_setup: count=%0d head=%0d, required 5/2", fifo_count, res_id);
        end
        res_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || fifo_count !== 4'd0 || hit_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: valid=%0b count=%0d hit=%0d, required 0/0/0",
                     res_valid, fifo_count, hit_count);
        end
        res_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        pulse(1'b0, 1'b1);
        checks++;
        if (res_id !== 8'd0 || fifo_count !== 4'd1 || timeout_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL post_reset_id: id=%0d count=%0d tmo=%0d, required 0/1/1",
                     res_id, fifo_count, timeout_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_ray();
        test_back_to_back();
        test_overflow();
        test_full_pop_cap();
        test_clear_stats();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
